// File: rtl/mem_fifo_sched_if.sv
// Handshake and memory-core bus bundle for mem_fifo_sched.
// The scheduler connects through the master modport; the producers, consumer
// and memory core side connect through the slave modport.
interface mem_fifo_sched_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  req0_valid;
  logic [DATA_WIDTH-1:0] req0_data;
  logic                  req0_ready;
  logic                  req1_valid;
  logic [DATA_WIDTH-1:0] req1_data;
  logic                  req1_ready;
  logic                  mem_wen;
  logic [DATA_WIDTH-1:0] mem_data_in;
  logic                  mem_full;
  logic                  mem_ren;
  logic [DATA_WIDTH-1:0] mem_data_out;
  logic                  mem_valid_out;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_ready;

  modport master (
    input  req0_valid, req0_data, req1_valid, req1_data,
    output req0_ready, req1_ready,
    output mem_wen, mem_data_in, mem_ren,
    input  mem_full, mem_data_out, mem_valid_out,
    output out_valid, out_data,
    input  out_ready
  );

  modport slave (
    output req0_valid, req0_data, req1_valid, req1_data,
    input  req0_ready, req1_ready,
    input  mem_wen, mem_data_in, mem_ren,
    output mem_full, mem_data_out, mem_valid_out,
    input  out_valid, out_data,
    output out_ready
  );
endinterface

// File: rtl/mem_fifo_sched.sv
// Scheduler for the memory core in FIFO mode: round-robin write arbitration
// between two producers, occupancy tracking, credit-limited read issue into a
// 2-entry output buffer, and a fixed-length flush sequence.
module mem_fifo_sched #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 16,
  parameter int RD_LAT     = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  mem_fifo_sched_if.master        bus,
  output logic [$clog2(DEPTH):0]  occupancy,
  output logic                    busy
);
  localparam int OCC_W = $clog2(DEPTH) + 1;

  typedef enum logic {RUN, FLUSH} state_t;

  state_t                state;
  logic [1:0]            fl_cnt;
  logic                  rr;
  logic [RD_LAT-1:0]     inflight;
  logic [DATA_WIDTH-1:0] obuf [2];
  logic [1:0]            ocnt;
  logic                  owr;
  logic                  ord;

  logic                  run;
  logic                  can_write;
  logic                  gnt0;
  logic                  gnt1;
  logic                  push;
  logic                  pop;
  logic [2:0]            infl_cnt;
  logic [2:0]            held;

  // Arbitration, read issue and output presentation. Everything is gated by
  // reset so the handshake outputs read 0 while reset is held low.
  always_comb begin
    run       = reset && (state == RUN);
    can_write = run && !bus.mem_full && (occupancy < OCC_W'(DEPTH));
    gnt0      = can_write && bus.req0_valid && (!bus.req1_valid || !rr);
    gnt1      = can_write && bus.req1_valid && (!bus.req0_valid || rr);

    bus.req0_ready  = gnt0;
    bus.req1_ready  = gnt1;
    bus.mem_wen     = gnt0 || gnt1;
    bus.mem_data_in = gnt0 ? bus.req0_data : (gnt1 ? bus.req1_data : '0);

    infl_cnt = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      infl_cnt = infl_cnt + {2'b00, inflight[i]};
    end

    // A word leaving the buffer this cycle frees its slot for a read issued
    // in the same cycle; this is what allows 1 word/cycle at RD_LAT = 1.
    pop  = (ocnt != 2'd0) && bus.out_ready;
    held = {1'b0, ocnt} - {2'b00, pop} + infl_cnt;

    bus.mem_ren   = run && (occupancy != '0) && (held < 3'd2);
    push          = run && bus.mem_valid_out;
    bus.out_valid = (ocnt != 2'd0);
    bus.out_data  = (ocnt != 2'd0) ? obuf[ord] : '0;
  end

  // Mode FSM: flush enters FLUSH for RD_LAT+1 cycles; a repeated flush restarts the count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= RUN;
      fl_cnt <= '0;
      busy   <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (flush) begin
            state  <= FLUSH;
            fl_cnt <= 2'(RD_LAT);
            busy   <= 1'b1;
          end
        end
        FLUSH: begin
          if (flush) begin
            fl_cnt <= 2'(RD_LAT);
          end else if (fl_cnt == 2'd0) begin
            state <= RUN;
            busy  <= 1'b0;
          end else begin
            fl_cnt <= fl_cnt - 2'd1;
          end
        end
        default: begin
          state <= RUN;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Occupancy, round-robin pointer and in-flight read strobes; flush clears them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      occupancy <= '0;
      rr        <= 1'b0;
      inflight  <= '0;
    end else if (flush) begin
      occupancy <= '0;
      rr        <= 1'b0;
      inflight  <= '0;
    end else begin
      case ({bus.mem_wen, bus.mem_ren})
        2'b10:   occupancy <= occupancy + OCC_W'(1);
        2'b01:   occupancy <= occupancy - OCC_W'(1);
        default: occupancy <= occupancy;
      endcase
      if (gnt0) begin
        rr <= 1'b1;
      end else if (gnt1) begin
        rr <= 1'b0;
      end
      inflight <= (inflight << 1) | RD_LAT'(bus.mem_ren);
    end
  end

  // Output buffer control: count and pointers of the 2-entry return FIFO.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ocnt <= '0;
      owr  <= 1'b0;
      ord  <= 1'b0;
    end else if (flush) begin
      ocnt <= '0;
      owr  <= 1'b0;
      ord  <= 1'b0;
    end else begin
      if (push) begin
        owr <= ~owr;
      end
      if (pop) begin
        ord <= ~ord;
      end
      ocnt <= ocnt + 2'(push) - 2'(pop);
    end
  end

  // Output buffer storage: data words only, qualified by the count above.
  always_ff @(posedge clk) begin
    if (push) begin
      obuf[owr] <= bus.mem_data_out;
    end
  end
endmodule

// File: tb/tb_mem_fifo_sched.sv
// Self-checking bench for mem_fifo_sched with a behavioural FIFO-mode memory
// core and an in-order scoreboard from producer acceptance to consumer output.
module tb_mem_fifo_sched;
  localparam int DW     = 16;
  localparam int DEPTH  = 16;
  localparam int RD_LAT = 1;

  logic                 clk;
  logic                 reset;
  logic                 flush;
  logic [$clog2(DEPTH):0] occupancy;
  logic                 busy;

  mem_fifo_sched_if #(.DATA_WIDTH(DW)) bus ();

  mem_fifo_sched #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .RD_LAT(RD_LAT)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .bus       (bus),
    .occupancy (occupancy),
    .busy      (busy)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [DW-1:0] src0[$];
  logic [DW-1:0] src1[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] core_q[$];
  logic          line_v [RD_LAT];
  logic [DW-1:0] line_d [RD_LAT];

  int            rdy_mode;
  bit            force_full;
  bit            flush_req;
  bit            inject_v;
  logic [DW-1:0] inject_d;
  bit            chk_alt;
  int            exp_side;
  int            acc;
  int            issued;
  int            consumed;
  int            first_gnt;
  int            first_out;
  int            rel_cyc;
  int            gnt_exp;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic clear_model();
    exp_q.delete();
    core_q.delete();
    for (int k = 0; k < RD_LAT; k++) begin
      line_v[k] = 1'b0;
      line_d[k] = '0;
    end
    issued   = 0;
    consumed = 0;
  endtask

  // One clock cycle: observe at the falling edge, then drive after the rising edge.
  task automatic tick();
    logic          nv;
    logic [DW-1:0] nd;
    logic [DW-1:0] w;
    logic          g0;
    logic          g1;
    @(negedge clk);
    nv = 1'b0;
    nd = '0;
    g0 = bus.req0_valid && bus.req0_ready;
    g1 = bus.req1_valid && bus.req1_ready;
    if (bus.mem_full) chk_eq("full_block", {bus.req0_ready, bus.req1_ready, bus.mem_wen}, 0);
    if (busy) chk_eq("busy_block", {bus.req0_ready, bus.req1_ready, bus.mem_wen, bus.mem_ren}, 0);
    if (g0 || g1) begin
      chk_eq("one_grant", g0 && g1, 0);
      if (g0) w = src0.pop_front();
      else    w = src1.pop_front();
      chk_eq("wdata", bus.mem_data_in, w);
      chk_eq("wen", bus.mem_wen, 1);
      chk_eq("occ_max", occupancy < DEPTH, 1);
      exp_q.push_back(w);
      acc++;
      if (first_gnt < 0) first_gnt = cyc;
      if (chk_alt) begin
        chk_eq("rr_side", g1, exp_side);
        exp_side ^= 1;
      end
    end
    if (bus.mem_wen) core_q.push_back(bus.mem_data_in);
    if (bus.mem_ren) begin
      chk_eq("ren_nonempty", core_q.size() != 0, 1);
      nv = 1'b1;
      if (core_q.size() != 0) nd = core_q.pop_front();
      issued++;
    end
    if (bus.out_valid && bus.out_ready) begin
      consumed++;
      if (exp_q.size() == 0) chk_eq("spurious_out", bus.out_valid, 0);
      else                   chk_eq("out_data", bus.out_data, exp_q.pop_front());
    end
    if (bus.out_valid && first_out < 0) first_out = cyc;
    if (bus.mem_ren) chk_eq("credit", (issued - consumed) <= 2, 1);
    @(posedge clk);
    cyc++;
    #1;
    for (int k = RD_LAT - 1; k > 0; k--) begin
      line_v[k] = line_v[k-1];
      line_d[k] = line_d[k-1];
    end
    line_v[0] = nv;
    line_d[0] = nd;
    bus.mem_valid_out = line_v[RD_LAT-1] || inject_v;
    bus.mem_data_out  = inject_v ? inject_d : (line_v[RD_LAT-1] ? line_d[RD_LAT-1] : '0);
    bus.mem_full      = force_full;
    flush             = flush_req;
    bus.req0_valid    = (src0.size() != 0);
    bus.req0_data     = (src0.size() != 0) ? src0[0] : '0;
    bus.req1_valid    = (src1.size() != 0);
    bus.req1_data     = (src1.size() != 0) ? src1[0] : '0;
    case (rdy_mode)
      0:       bus.out_ready = 1'b0;
      1:       bus.out_ready = 1'b1;
      default: bus.out_ready = ~bus.out_ready;
    endcase
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((src0.size() != 0 || src1.size() != 0 || exp_q.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    repeat (4) tick();
    chk_eq("drain_left", exp_q.size() + src0.size() + src1.size(), 0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    src0.delete();
    src1.delete();
    clear_model();
    force_full = 1'b0;
    flush_req  = 1'b0;
    inject_v   = 1'b0;
    chk_alt    = 1'b0;
    rdy_mode   = 1;
    tick();
    tick();
    reset     = 1'b1;
    acc       = 0;
    first_gnt = -1;
    first_out = -1;
  endtask

  initial begin
    reset             = 1'b0;
    flush             = 1'b0;
    bus.req0_valid    = 1'b1;
    bus.req0_data     = 16'h0005;
    bus.req1_valid    = 1'b0;
    bus.req1_data     = '0;
    bus.mem_full      = 1'b0;
    bus.mem_data_out  = '0;
    bus.mem_valid_out = 1'b0;
    bus.out_ready     = 1'b1;
    rdy_mode  = 1;
    force_full = 1'b0;
    flush_req = 1'b0;
    inject_v  = 1'b0;
    inject_d  = '0;
    chk_alt   = 1'b0;
    exp_side  = 0;
    acc       = 0;
    first_gnt = -1;
    first_out = -1;
    clear_model();

    // Reset values, with a producer already requesting.
    #12;
    chk_eq("rst_req0_ready", bus.req0_ready, 0);
    chk_eq("rst_mem_wen", bus.mem_wen, 0);
    chk_eq("rst_mem_data_in", bus.mem_data_in, 0);
    chk_eq("rst_mem_ren", bus.mem_ren, 0);
    chk_eq("rst_out_valid", bus.out_valid, 0);
    chk_eq("rst_out_data", bus.out_data, 0);
    chk_eq("rst_occupancy", occupancy, 0);
    chk_eq("rst_busy", busy, 0);
    do_reset();

    // Single producer, latency from first grant to first out_valid.
    for (int i = 1; i <= 5; i++) src0.push_back(DW'(i));
    drain(100);
    chk_eq("t1_latency", first_out - first_gnt, RD_LAT + 2);
    chk_eq("t1_occupancy", occupancy, 0);
    chk_eq("t1_accepted", acc, 5);

    // Contention: grants must alternate starting with req0.
    do_reset();
    chk_alt  = 1'b1;
    exp_side = 0;
    for (int i = 0; i < 6; i++) begin
      src0.push_back(16'hA000 + DW'(i));
      src1.push_back(16'hB000 + DW'(i));
    end
    drain(100);
    chk_alt = 1'b0;
    chk_eq("t2_accepted", acc, 12);

    // Full: consumer stalled, occupancy limit, then core full flag.
    do_reset();
    rdy_mode = 0;
    for (int i = 0; i < 20; i++) src0.push_back(16'hC000 + DW'(i));
    repeat (40) tick();
    #1;
    chk_eq("t3_accepted", acc, DEPTH + 2);
    chk_eq("t3_occupancy", occupancy, DEPTH);
    chk_eq("t3_out_valid", bus.out_valid, 1);
    chk_eq("t3_ren_stall", bus.mem_ren, 0);
    chk_eq("t3_ready_at_depth", bus.req0_ready, 0);
    force_full = 1'b1;
    rdy_mode   = 1;
    repeat (8) tick();
    chk_eq("t3_occ_dropped", occupancy < DEPTH, 1);
    force_full = 1'b0;
    drain(200);
    chk_eq("t3_total", acc, 20);

    // Backpressure: out_ready toggling every cycle.
    do_reset();
    rdy_mode = 2;
    for (int i = 0; i < 10; i++) src0.push_back(16'h4000 + DW'(i));
    drain(300);
    chk_eq("t4_consumed", consumed, 10);

    // Flush with queued words and a late return from the core.
    do_reset();
    rdy_mode = 0;
    for (int i = 0; i < 6; i++) src0.push_back(16'h5000 + DW'(i));
    repeat (12) tick();
    chk_eq("t5_pre_valid", bus.out_valid, 1);
    chk_eq("t5_pre_occ", occupancy, 4);
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    inject_v  = 1'b1;
    inject_d  = 16'hDEAD;
    tick();
    inject_v  = 1'b0;
    clear_model();
    first_gnt = -1;
    rdy_mode  = 1;
    src0.push_back(16'h1234);
    chk_eq("t5_busy1", busy, 1);
    chk_eq("t5_occ", occupancy, 0);
    chk_eq("t5_valid1", bus.out_valid, 0);
    tick();
    chk_eq("t5_busy2", busy, 1);
    chk_eq("t5_discard", bus.out_valid, 0);
    tick();
    chk_eq("t5_busy_end", busy, 0);
    gnt_exp = cyc;
    drain(100);
    chk_eq("t5_first_gnt", first_gnt, gnt_exp);
    chk_eq("t5_consumed", consumed, 1);

    // Asynchronous reset in the middle of traffic.
    do_reset();
    rdy_mode = 0;
    for (int i = 0; i < 30; i++) src0.push_back(16'h6000 + DW'(i));
    repeat (10) tick();
    chk_eq("t6_pre_valid", bus.out_valid, 1);
    #2;
    reset = 1'b0;
    #1;
    chk_eq("t6_out_valid", bus.out_valid, 0);
    chk_eq("t6_out_data", bus.out_data, 0);
    chk_eq("t6_occupancy", occupancy, 0);
    chk_eq("t6_mem_wen", bus.mem_wen, 0);
    chk_eq("t6_req0_ready", bus.req0_ready, 0);
    chk_eq("t6_mem_ren", bus.mem_ren, 0);
    chk_eq("t6_busy", busy, 0);
    src0.delete();
    src1.delete();
    clear_model();
    tick();
    tick();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) src0.push_back(16'h7000 + DW'(i));
    bus.req0_valid = 1'b1;
    bus.req0_data  = src0[0];
    rdy_mode       = 1;
    bus.out_ready  = 1'b1;
    rel_cyc        = cyc;
    first_gnt      = -1;
    drain(100);
    chk_eq("t6_first_gnt", first_gnt, rel_cyc);
    chk_eq("t6_consumed", consumed, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
